lif_scheduler: RTL and testbench

- Round-robin scheduler that shares one LIF neuron unit among N requesters, such as PE result channels.
- Picks a requester, points the LIF input mux at it, and pulses start/result_val to the LIF unit.
- Waits for the LIF done signal, then returns the T-bit spike train, requester id and spike count on a valid/ready response port.
- Holds the LIF firing threshold register; a watchdog recovers the block if the LIF unit stalls.

---
 rtl/lif_scheduler.sv | 121 ++++++++++++
 tb/tb_lif_scheduler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/lif_scheduler.sv
// lif_scheduler: round-robin arbiter sharing one LIF neuron unit among N requesters
module lif_scheduler #(
  parameter int N = 4,
  parameter int T = 16,
  parameter int Q = 10,
  parameter int TIMEOUT = 64,
  parameter logic [Q-1:0] THR_RST = 10'd512
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           req,
  output logic [N-1:0]           grant,
  output logic                   lif_start,
  output logic                   lif_result_val,
  output logic [$clog2(N)-1:0]   lif_sel,
  output logic [Q-1:0]           lif_threshold,
  input  logic                   lif_done,
  input  logic [T-1:0]           lif_spike,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [$clog2(N)-1:0]   resp_id,
  output logic [T-1:0]           resp_spikes,
  output logic [$clog2(T):0]     resp_count,
  input  logic                   cfg_thr_we,
  input  logic [Q-1:0]           cfg_thr,
  output logic                   busy,
  output logic                   err_timeout,
  input  logic                   err_clr
);
  localparam int W  = $clog2(N);
  localparam int CW = $clog2(T) + 1;
  localparam int DW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [W-1:0] ptr, win, pick, win_inc;
  logic found, done_hit, tmo_hit;
  logic [DW-1:0] cnt;
  logic [Q-1:0] thr_pend;
  logic [CW-1:0] pop;
  int k;
  assign win_inc        = (win == W'(N - 1)) ? '0 : win + 1'b1;
  assign done_hit       = (state == WAIT) && lif_done;
  assign tmo_hit        = (state == WAIT) && !lif_done && (cnt == DW'(TIMEOUT - 1));
  assign lif_start      = (state == LAUNCH);
  assign lif_result_val = (state == LAUNCH);
  assign lif_sel        = win;
  assign resp_valid     = (state == RESP);
  assign busy           = (state != IDLE);
  assign grant          = (done_hit && !rst) ? (N'(1) << win) : '0;
  // first requesting index at or after the pointer, wrapping at N-1
  always_comb begin
    pick  = '0;
    found = 1'b0;
    k     = 0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr) + i;
      k = (k >= N) ? k - N : k;
      if (!found && req[k]) begin
        pick  = W'(k);
        found = 1'b1;
      end
    end
  end
  // popcount of the incoming spike train
  always_comb begin
    pop = '0;
    for (int i = 0; i < T; i++) pop = pop + CW'(lif_spike[i]);
  end
  // next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = found ? LAUNCH : IDLE;
      LAUNCH:  state_n = WAIT;
      WAIT:    state_n = done_hit ? RESP : (tmo_hit ? IDLE : WAIT);
      RESP:    state_n = resp_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  // state, arbitration pointer, winner and watchdog
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      win   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && found) win <= pick;
      if (done_hit || tmo_hit) ptr <= win_inc;
      cnt <= (state == LAUNCH) ? '0 : (state == WAIT) ? cnt + 1'b1 : cnt;
    end
  end
  // response capture on LIF completion
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_id     <= '0;
      resp_spikes <= '0;
      resp_count  <= '0;
    end else if (done_hit) begin
      resp_id     <= win;
      resp_spikes <= lif_spike;
      resp_count  <= pop;
    end
  end
  // threshold staging: pending write applied only while idle so a run sees one value
  always_ff @(posedge clk) begin
    if (rst) begin
      thr_pend      <= THR_RST;
      lif_threshold <= THR_RST;
    end else begin
      if (cfg_thr_we) thr_pend <= cfg_thr;
      if (state == IDLE) lif_threshold <= thr_pend;
    end
  end
  // sticky watchdog flag, set dominates clear
  always_ff @(posedge clk) begin
    if (rst) err_timeout <= 1'b0;
    else err_timeout <= tmo_hit | (err_timeout & ~err_clr);
  end
endmodule

// File: tb/tb_lif_scheduler.sv
// tb_lif_scheduler: directed self-checking bench for lif_scheduler
module tb_lif_scheduler;
  logic clk = 0, rst = 1;
  logic [3:0] req = 0, grant;
  logic lif_start, lif_result_val, lif_done = 0, resp_valid, resp_ready = 0;
  logic [1:0] lif_sel, resp_id;
  logic [9:0] lif_threshold, cfg_thr = 0;
  logic [15:0] lif_spike = 0, resp_spikes;
  logic [4:0] resp_count;
  logic cfg_thr_we = 0, busy, err_timeout, err_clr = 0;
  int n_checks = 0, n_fail = 0;

  lif_scheduler dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant), .lif_start(lif_start),
    .lif_result_val(lif_result_val), .lif_sel(lif_sel), .lif_threshold(lif_threshold),
    .lif_done(lif_done), .lif_spike(lif_spike), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_id(resp_id), .resp_spikes(resp_spikes),
    .resp_count(resp_count), .cfg_thr_we(cfg_thr_we), .cfg_thr(cfg_thr),
    .busy(busy), .err_timeout(err_timeout), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) tick();
    rst = 0;
  endtask

  // LIF unit stand-in: wait for a launch, answer after dly cycles, return at the RESP cycle
  task automatic lif_run(input int dly, input logic [15:0] spk, output logic started,
                         output logic [1:0] sel, output logic [3:0] g, output int starts);
    started = 0; sel = 0; g = 0; starts = 0;
    for (int i = 0; i < 20 && !started; i++) begin
      tick();
      if (lif_start) begin started = 1; sel = lif_sel; starts++; end
    end
    if (started) begin
      repeat (dly) begin tick(); if (lif_start) starts++; end
      lif_done = 1; lif_spike = spk;
      #1 g = grant;
      tick();
      lif_done = 0; lif_spike = 0;
      if (lif_start) starts++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({grant, lif_start, lif_result_val, lif_sel, resp_valid, resp_id, resp_spikes, resp_count, busy, err_timeout} !== 33'd0) begin
      n_fail++; $display("FAIL reset_outputs: got grant=%b start=%b sel=%0d rv=%b id=%0d sp=%h cnt=%0d busy=%b err=%b, want all 0",
        grant, lif_start, lif_sel, resp_valid, resp_id, resp_spikes, resp_count, busy, err_timeout);
    end
    n_checks++;
    if (lif_threshold !== 10'd512) begin n_fail++; $display("FAIL reset_threshold: got %0d want 512", lif_threshold); end
  endtask

  task automatic test_single();
    logic st; logic [1:0] sel; logic [3:0] g; int ns;
    resp_ready = 1; req = 4'b0100;
    lif_run(3, 16'hA5A5, st, sel, g, ns);
    req = 0;
    n_checks++;
    if (st !== 1'b1 || sel !== 2'd2) begin n_fail++; $display("FAIL single_launch: got started=%b sel=%0d want 1 2", st, sel); end
    n_checks++;
    if (ns !== 1) begin n_fail++; $display("FAIL single_start_count: got %0d want 1", ns); end
    n_checks++;
    if (g !== 4'b0100) begin n_fail++; $display("FAIL single_grant: got %b want 0100", g); end
    n_checks++;
    if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_spikes !== 16'hA5A5 || resp_count !== 5'd8) begin
      n_fail++; $display("FAIL single_resp: got v=%b id=%0d sp=%h cnt=%0d want 1 2 a5a5 8", resp_valid, resp_id, resp_spikes, resp_count);
    end
    tick();
    n_checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got v=%b busy=%b want 0 0", resp_valid, busy); end
  endtask

  task automatic test_rr();
    logic st; logic [1:0] sel; logic [3:0] g; int ns;
    logic [15:0] spk [5] = '{16'h0001, 16'h0003, 16'hFFFF, 16'h8000, 16'h0F0F};
    int cnt [5] = '{1, 2, 16, 1, 8};
    do_reset();
    resp_ready = 1; req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      lif_run(1 + k, spk[k], st, sel, g, ns);
      if (k == 4) req = 0;
      n_checks++;
      if (st !== 1'b1 || sel !== 2'(k % 4) || ns !== 1) begin
        n_fail++; $display("FAIL rr_launch%0d: got started=%b sel=%0d starts=%0d want 1 %0d 1", k, st, sel, ns, k % 4);
      end
      n_checks++;
      if (g !== 4'(1 << (k % 4)) || resp_id !== 2'(k % 4) || resp_count !== 5'(cnt[k])) begin
        n_fail++; $display("FAIL rr_resp%0d: got grant=%b id=%0d cnt=%0d want %b %0d %0d", k, g, resp_id, resp_count, 4'(1 << (k % 4)), k % 4, cnt[k]);
      end
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic st; logic [1:0] sel; logic [3:0] g; int ns;
    resp_ready = 0; req = 4'b0010;
    lif_run(2, 16'h1234, st, sel, g, ns);
    req = 4'b0001;
    n_checks++;
    if (st !== 1'b1 || sel !== 2'd1 || g !== 4'b0010) begin n_fail++; $display("FAIL bp_launch: got started=%b sel=%0d grant=%b want 1 1 0010", st, sel, g); end
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_spikes !== 16'h1234 || resp_count !== 5'd5 || lif_start !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold%0d: got v=%b id=%0d sp=%h cnt=%0d start=%b want 1 1 1234 5 0", i, resp_valid, resp_id, resp_spikes, resp_count, lif_start);
      end
      tick();
    end
    resp_ready = 1;
    tick();
    n_checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL bp_idle: got v=%b busy=%b want 0 0", resp_valid, busy); end
    lif_run(1, 16'h0000, st, sel, g, ns);
    req = 0;
    n_checks++;
    if (st !== 1'b1 || sel !== 2'd0 || g !== 4'b0001 || resp_count !== 5'd0) begin
      n_fail++; $display("FAIL bp_next: got started=%b sel=%0d grant=%b cnt=%0d want 1 0 0001 0", st, sel, g, resp_count);
    end
    tick();
  endtask

  task automatic test_timeout();
    logic st; logic [1:0] sel; logic [3:0] g; int ns, n; logic bad, seen;
    do_reset();
    resp_ready = 1; req = 4'b0011; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin tick(); seen = lif_start; end
    n_checks++;
    if (seen !== 1'b1 || lif_sel !== 2'd0) begin n_fail++; $display("FAIL tmo_launch: got started=%b sel=%0d want 1 0", seen, lif_sel); end
    n = 0; bad = 0;
    while (!err_timeout && n < 200) begin
      tick(); n++;
      if (grant !== 4'b0 || resp_valid !== 1'b0) bad = 1;
    end
    n_checks++;
    if (err_timeout !== 1'b1 || n !== 65) begin n_fail++; $display("FAIL tmo_flag: got err=%b after %0d cycles want 1 after 65", err_timeout, n); end
    n_checks++;
    if (bad !== 1'b0) begin n_fail++; $display("FAIL tmo_no_grant: got stray grant/resp=%b want 0", bad); end
    lif_run(1, 16'h00FF, st, sel, g, ns);
    req = 0;
    n_checks++;
    if (st !== 1'b1 || sel !== 2'd1 || g !== 4'b0010 || resp_id !== 2'd1) begin
      n_fail++; $display("FAIL tmo_next: got started=%b sel=%0d grant=%b id=%0d want 1 1 0010 1", st, sel, g, resp_id);
    end
    tick();
    n_checks++;
    if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %b want 1", err_timeout); end
    err_clr = 1;
    tick();
    err_clr = 0;
    n_checks++;
    if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_clear: got %b want 0", err_timeout); end
  endtask

  task automatic test_threshold();
    n_checks++;
    if (lif_threshold !== 10'd512) begin n_fail++; $display("FAIL thr_initial: got %0d want 512", lif_threshold); end
    resp_ready = 0; req = 4'b0100;
    tick();
    tick();
    cfg_thr_we = 1; cfg_thr = 10'd300;
    tick();
    cfg_thr_we = 0;
    n_checks++;
    if (lif_threshold !== 10'd512) begin n_fail++; $display("FAIL thr_wait: got %0d want 512", lif_threshold); end
    lif_done = 1;
    tick();
    lif_done = 0; req = 0;
    n_checks++;
    if (resp_valid !== 1'b1 || lif_threshold !== 10'd512) begin n_fail++; $display("FAIL thr_resp: got v=%b thr=%0d want 1 512", resp_valid, lif_threshold); end
    resp_ready = 1;
    tick();
    tick();
    n_checks++;
    if (lif_threshold !== 10'd300 || busy !== 1'b0) begin n_fail++; $display("FAIL thr_idle: got thr=%0d busy=%b want 300 0", lif_threshold, busy); end
  endtask

  task automatic test_reset_midrun();
    req = 4'b1000;
    repeat (3) tick();
    n_checks++;
    if (busy !== 1'b1 || lif_sel !== 2'd3) begin n_fail++; $display("FAIL mid_busy: got busy=%b sel=%0d want 1 3", busy, lif_sel); end
    rst = 1;
    tick();
    rst = 0; req = 0;
    n_checks++;
    if ({grant, lif_start, lif_sel, resp_valid, resp_id, resp_count, busy, err_timeout} !== 16'd0 || lif_threshold !== 10'd512) begin
      n_fail++; $display("FAIL mid_reset: got grant=%b start=%b sel=%0d v=%b busy=%b thr=%0d want zeros thr 512", grant, lif_start, lif_sel, resp_valid, busy, lif_threshold);
    end
    lif_done = 1; lif_spike = 16'hFFFF;
    #1;
    n_checks++;
    if (grant !== 4'b0) begin n_fail++; $display("FAIL mid_stray_grant: got %b want 0000", grant); end
    tick();
    lif_done = 0; lif_spike = 0;
    n_checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0 || resp_spikes !== 16'h0) begin
      n_fail++; $display("FAIL mid_stray_resp: got v=%b busy=%b sp=%h want 0 0 0", resp_valid, busy, resp_spikes);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_backpressure();
    test_timeout();
    test_threshold();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, want finish");
    $fatal(1);
  end
endmodule
